// File: rtl/dmem_hs.sv
// Handshaked data memory for the MEM stage: one outstanding request, LATENCY-cycle response, lane-aligned extended loads.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_hs #(
  parameter int LINES   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic        dm_req_we,
  input  logic [1:0]  dm_req_size,
  input  logic        dm_req_unsigned,
  input  logic [31:0] dm_req_addr,
  input  logic [31:0] dm_req_wdata,
  output logic        dm_rsp_valid,
  input  logic        dm_rsp_ready,
  output logic [31:0] dm_rsp_rdata,
  output logic        dm_rsp_err
);
  localparam int AW = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] mem [LINES];
  logic [31:0] rsp_rdata_reg;

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_byte, is_half;
  logic          misal;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword;
  logic [7:0]    rbytes [4];
  logic [15:0]   sel_half;
  logic [31:0]   load_data;
  logic          unused_addr;

  assign accept      = dm_req_valid & (state_reg == IDLE);
  assign idx         = dm_req_addr[2 +: AW];
  assign lane        = dm_req_addr[1:0];
  assign is_byte     = (dm_req_size == 2'b00);
  assign is_half     = (dm_req_size == 2'b01);
  assign unused_addr = ^dm_req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = (is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Replicate store data across lanes so every byte enable sees the right bits.
  always_comb begin
    be = 4'b1111;
    wd = dm_req_wdata;
    if (is_byte) begin
      be = 4'b0001 << lane;
      wd = {4{dm_req_wdata[7:0]}};
    end else if (is_half) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
      wd = {2{dm_req_wdata[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (accept && dm_req_we && !misal) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  assign rword = mem[idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rbytes[gi] = rword[8*gi +: 8];
    end
  endgenerate

  assign sel_half = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    if (is_byte)
      load_data = {{24{~dm_req_unsigned & rbytes[lane][7]}}, rbytes[lane]};
    else if (is_half)
      load_data = {{16{~dm_req_unsigned & sel_half[15]}}, sel_half};
    if (dm_req_we || misal)
      load_data = '0;
  end

  // Response is formed at acceptance so it is ready even for LATENCY==1.
  always_ff @(posedge clk) begin
    if (rst)
      rsp_rdata_reg <= '0;
    else if (accept)
      rsp_rdata_reg <= load_data;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic rsp_err_reg;
  always_ff @(posedge clk) begin
    if (rst)
      rsp_err_reg <= 1'b0;
    else if (accept)
      rsp_err_reg <= misal;
  end
  assign dm_rsp_err = rsp_err_reg;
`else
  assign dm_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (dm_req_valid) begin
        if (LATENCY == 1) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          cnt_next   = 3'(LATENCY - 2);
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) state_next = RESP;
        else cnt_next = cnt_reg - 3'd1;
      end
      RESP: if (dm_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dm_req_ready = (state_reg == IDLE);
  assign dm_rsp_valid = (state_reg == RESP);
  assign dm_rsp_rdata = rsp_rdata_reg;
endmodule
